myo_spi_slave: RTL and testbench
================================

# myo_spi_slave

SPI slave that emulates the motor-board end of the myocontrol SPI link. It answers the myocontrol master's `sck`/`mosi`/`ss_n` frames, driving `miso` with a status frame latched from fabric registers, and captures the master's command words. It sits in the FPGA fabric as a loopback/emulation target for driving myocontrol without physical motor boards, and as a building block for fabric-side motor-board models. All SPI pins are oversampled in the `clock` domain; no logic runs on `sck`.

## Interface
- `WORD_WIDTH`, 16, bits per SPI word, MSB first.
- `FRAME_WORDS`, 4, words per complete frame (≥2).
- `clock`  in  1  system clock; must be ≥ 8× the `sck` frequency.
- `reset`  in  1  synchronous, active-high reset.
- `sck`  in  1  SPI clock from master, mode 0 (CPOL=0, CPHA=0); asynchronous.
- `ss_n`  in  1  active-low slave select; asynchronous.
- `mosi`  in  1  master-out data; asynchronous.
- `miso`  out  1  slave-out data. Driven 0 whenever the block is not in ACTIVE.
- `tx_frame`  in  `FRAME_WORDS*WORD_WIDTH`  status frame. Word 0 is in the top bits and is shifted out first.
- `rx_frame`  out  `FRAME_WORDS*WORD_WIDTH`  last good command frame, word 0 in the top bits.
- `rx_valid`  out  1  one-cycle pulse when `rx_frame` updates.
- `frame_error`  out  1  one-cycle pulse when a frame is rejected.
- `busy`  out  1  high while in ACTIVE.

## Operation
- **Input conditioning.** `sck`, `ss_n` and `mosi` each pass through a 2-FF synchronizer. Edges of `sck` and `ss_n` are detected on the synchronized signals.
- **State IDLE.**
  - On a synchronized `ss_n` falling edge: latch `tx_frame` into the shift bank, clear `bit_cnt`, `word_cnt` and the overrun flag, then go to ACTIVE.
  - If `ss_n` is already low on arrival in IDLE, no frame starts. The block waits for `ss_n` to go high.
- **State ACTIVE.**
  - `miso` presents the current MSB of the outgoing word.
  - On `sck` rising: shift synchronized `mosi` into the rx shift register and increment `bit_cnt`.
  - On `sck` falling: shift the tx word left.
  - When `bit_cnt` wraps from `WORD_WIDTH-1` to 0: store the rx word into slot `word_cnt` of a staging bank and increment `word_cnt`.
  - Words received after `FRAME_WORDS` set the overrun flag. They are discarded, and `miso` is 0 for them.
  - On a synchronized `ss_n` rising edge: go to DONE.
- **State DONE (1 cycle).**
  - The frame is good if `word_cnt == FRAME_WORDS`, `bit_cnt == 0` and there is no overrun. In that case copy the staging bank to `rx_frame` and pulse `rx_valid`.
  - Otherwise pulse `frame_error` and leave `rx_frame` unchanged.
  - Return to IDLE.
- **Simultaneous events.** If the `ss_n` rise is detected in the same cycle as an `sck` edge, the `sck` edge is ignored.
- **Reset mid-frame.** The frame is discarded and all outputs return to their reset values. The block re-arms only after `ss_n` has been seen high.
- **Reset values.** `miso`=0, `rx_frame`=0, `rx_valid`=0, `frame_error`=0, `busy`=0. State is IDLE and both counters are 0.

## Timing
- `ss_n` fall at the pin → `busy`=1 and `miso` = tx word 0 bit 15 after 3 `clock` cycles (±1 for synchronizer phase). The master must wait ≥4 `clock` cycles before the first `sck` rise.
- `sck` fall at the pin → next `miso` bit valid after 3–4 `clock` cycles, which is within the half-period guaranteed by the 8× ratio.
- `ss_n` rise at the pin → `rx_valid` or `frame_error` pulse after 4 `clock` cycles (±1). `busy` falls in the same cycle as the pulse.
- Minimum `ss_n` high time between frames is 4 `clock` cycles.
- `tx_frame` is sampled only in the IDLE→ACTIVE cycle. Changes during a frame have no effect.

## Configuration
- **`MYO_SPI_SLAVE_CHECKSUM_EN` defined:**
  - The last tx word shifted out is the XOR of tx words 0..`FRAME_WORDS-2`. The low word of `tx_frame` is ignored.
  - A received frame is good only if its last word equals the XOR of its preceding words. On mismatch the block pulses `frame_error` and does not update `rx_frame`.
- **Not defined:** all `FRAME_WORDS` words are plain data in both directions and no checksum is applied.

## Test plan
- **Good frame, checksum off.** `FRAME_WORDS`=4, `tx_frame`=0x1111_2222_3333_4444, master sends 0xAAAA,0x5555,0x0F0F,0xF0F0 at `sck`=`clock`/8 → `miso` stream 0x1111,0x2222,0x3333,0x4444; `rx_frame`=0xAAAA_5555_0F0F_F0F0; one `rx_valid` pulse; no `frame_error`.
- **Short frame.** Master sends 3 words then raises `ss_n` → `frame_error` pulse; `rx_frame` unchanged.
- **Partial word.** Master sends 4 words plus 5 extra bits → `frame_error`.
- **Overrun.** Master sends 5 words → `frame_error`, and `miso`=0 throughout word 5.
- **Reset mid-frame.** `reset` for 1 cycle after 20 bits with `ss_n` still low → `busy`=0 and `miso`=0. No pulse when `ss_n` rises. The next full frame is received correctly.
- **Checksum on.** With `MYO_SPI_SLAVE_CHECKSUM_EN`, tx words 0x0001,0x0002,0x0004 → fourth `miso` word is 0x0007. Rx frame 0x0001,0x0002,0x0004,0x0007 → `rx_valid`. Rx frame 0x0001,0x0002,0x0004,0x0006 → `frame_error`.

Source files
------------

// File: rtl/myo_spi_slave.sv
// Oversampled mode-0 SPI slave emulating a myocontrol motor board: shifts out a latched status frame, captures command frames.
// Optional MYO_SPI_SLAVE_CHECKSUM_EN: last word in each direction is the XOR of the preceding words.
module myo_spi_slave #(
    parameter int WORD_WIDTH  = 16,
    parameter int FRAME_WORDS = 4
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              sck,
    input  logic                              ss_n,
    input  logic                              mosi,
    output logic                              miso,
    input  logic [FRAME_WORDS*WORD_WIDTH-1:0] tx_frame,
    output logic [FRAME_WORDS*WORD_WIDTH-1:0] rx_frame,
    output logic                              rx_valid,
    output logic                              frame_error,
    output logic                              busy
);
    localparam int FRAME_BITS = FRAME_WORDS * WORD_WIDTH;
    localparam int BIT_W      = $clog2(WORD_WIDTH);
    localparam int CNT_W      = $clog2(FRAME_WORDS + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_WIDTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

`ifdef MYO_SPI_SLAVE_CHECKSUM_EN
    // XOR of every word except the lowest (last-transmitted) one.
    function automatic logic [WORD_WIDTH-1:0] fold_xor(input logic [FRAME_BITS-1:0] frame);
        logic [WORD_WIDTH-1:0] acc;
        acc = '0;
        for (int i = 1; i < FRAME_WORDS; i++) begin
            acc = acc ^ frame[i*WORD_WIDTH +: WORD_WIDTH];
        end
        return acc;
    endfunction
`endif

    logic sck_meta_q, sck_sync_q, sck_prev_q;
    logic ss_meta_q, ss_sync_q, ss_prev_q;
    logic mosi_meta_q, mosi_sync_q;

    state_e                  state_q, state_d;
    logic [FRAME_BITS-1:0]   tx_shift_q, tx_shift_d;
    logic [WORD_WIDTH-1:0]   rx_shift_q, rx_shift_d;
    logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]        word_cnt_q, word_cnt_d;
    logic                    overrun_q, overrun_d;
    logic                    armed_q, armed_d;
    logic [WORD_WIDTH-1:0]   stage_q [FRAME_WORDS];
    logic [WORD_WIDTH-1:0]   stage_d [FRAME_WORDS];
    logic [FRAME_BITS-1:0]   rx_frame_q, rx_frame_d;
    logic                    rx_valid_q, rx_valid_d;
    logic                    frame_error_q, frame_error_d;
    logic                    busy_q, busy_d;
    logic                    miso_q, miso_d;

    logic                    sck_rise_s, sck_fall_s, ss_rise_s;
    logic [WORD_WIDTH-1:0]   rx_word_s;
    logic [FRAME_BITS-1:0]   stage_flat_s;
    logic [FRAME_BITS-1:0]   tx_load_s;
    logic                    frame_ok_s;

    // Two-flop synchronizers plus one history flop for edge detection; ss_n resets low so nothing starts until it is seen high.
    always_ff @(posedge clock) begin
        if (reset) begin
            sck_meta_q  <= 1'b0;
            sck_sync_q  <= 1'b0;
            sck_prev_q  <= 1'b0;
            ss_meta_q   <= 1'b0;
            ss_sync_q   <= 1'b0;
            ss_prev_q   <= 1'b0;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
        end else begin
            sck_meta_q  <= sck;
            sck_sync_q  <= sck_meta_q;
            sck_prev_q  <= sck_sync_q;
            ss_meta_q   <= ss_n;
            ss_sync_q   <= ss_meta_q;
            ss_prev_q   <= ss_sync_q;
            mosi_meta_q <= mosi;
            mosi_sync_q <= mosi_meta_q;
        end
    end

    assign sck_rise_s = sck_sync_q & ~sck_prev_q;
    assign sck_fall_s = ~sck_sync_q & sck_prev_q;
    assign ss_rise_s  = ss_sync_q & ~ss_prev_q;
    assign rx_word_s  = {rx_shift_q[WORD_WIDTH-2:0], mosi_sync_q};

    // Flatten the staging bank with word 0 in the top bits.
    always_comb begin
        stage_flat_s = '0;
        for (int i = 0; i < FRAME_WORDS; i++) begin
            stage_flat_s[(FRAME_WORDS-1-i)*WORD_WIDTH +: WORD_WIDTH] = stage_q[i];
        end
    end

`ifdef MYO_SPI_SLAVE_CHECKSUM_EN
    assign tx_load_s  = {tx_frame[FRAME_BITS-1:WORD_WIDTH], fold_xor(tx_frame)};
    assign frame_ok_s = (word_cnt_q == FULL_CNT) && (bit_cnt_q == '0) && !overrun_q &&
                        (stage_q[FRAME_WORDS-1] == fold_xor(stage_flat_s));
`else
    assign tx_load_s  = tx_frame;
    assign frame_ok_s = (word_cnt_q == FULL_CNT) && (bit_cnt_q == '0) && !overrun_q;
`endif

    // Next-state and datapath: the whole frame shifts through one register so miso runs dry to 0 after the last word.
    always_comb begin
        state_d       = state_q;
        tx_shift_d    = tx_shift_q;
        rx_shift_d    = rx_shift_q;
        bit_cnt_d     = bit_cnt_q;
        word_cnt_d    = word_cnt_q;
        overrun_d     = overrun_q;
        armed_d       = 1'b0;
        stage_d       = stage_q;
        rx_frame_d    = rx_frame_q;
        rx_valid_d    = 1'b0;
        frame_error_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                armed_d = ss_sync_q;
                if (armed_q && !ss_sync_q) begin
                    tx_shift_d = tx_load_s;
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                    overrun_d  = 1'b0;
                    state_d    = ST_ACTIVE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (ss_rise_s) begin
                    state_d = ST_DONE;
                end else if (sck_rise_s) begin
                    rx_shift_d = rx_word_s;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        if (word_cnt_q < FULL_CNT) begin
                            for (int i = 0; i < FRAME_WORDS; i++) begin
                                if (word_cnt_q == CNT_W'(i)) begin
                                    stage_d[i] = rx_word_s;
                                end else begin
                                    stage_d[i] = stage_q[i];
                                end
                            end
                            word_cnt_d = word_cnt_q + CNT_W'(1);
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end else if (sck_fall_s) begin
                    tx_shift_d = {tx_shift_q[FRAME_BITS-2:0], 1'b0};
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_DONE: begin
                if (frame_ok_s) begin
                    rx_frame_d = stage_flat_s;
                    rx_valid_d = 1'b1;
                end else begin
                    frame_error_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        miso_d = (state_d == ST_ACTIVE) ? tx_shift_d[FRAME_BITS-1] : 1'b0;
    end

    // State and output registers; busy stays up through DONE so it drops together with the result pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            tx_shift_q    <= '0;
            rx_shift_q    <= '0;
            bit_cnt_q     <= '0;
            word_cnt_q    <= '0;
            overrun_q     <= 1'b0;
            armed_q       <= 1'b0;
            stage_q       <= '{default: '0};
            rx_frame_q    <= '0;
            rx_valid_q    <= 1'b0;
            frame_error_q <= 1'b0;
            busy_q        <= 1'b0;
            miso_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            tx_shift_q    <= tx_shift_d;
            rx_shift_q    <= rx_shift_d;
            bit_cnt_q     <= bit_cnt_d;
            word_cnt_q    <= word_cnt_d;
            overrun_q     <= overrun_d;
            armed_q       <= armed_d;
            stage_q       <= stage_d;
            rx_frame_q    <= rx_frame_d;
            rx_valid_q    <= rx_valid_d;
            frame_error_q <= frame_error_d;
            busy_q        <= busy_d;
            miso_q        <= miso_d;
        end
    end

    assign miso        = miso_q;
    assign rx_frame    = rx_frame_q;
    assign rx_valid    = rx_valid_q;
    assign frame_error = frame_error_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_myo_spi_slave.sv
// Randomized bench for myo_spi_slave: a bit-level SPI master plus a frame-level reference model.
// Define MYO_SPI_SLAVE_CHECKSUM_EN here as well as in the RTL to exercise the checksum build.
module tb_myo_spi_slave;
    localparam int WW = 16;
    localparam int FW = 4;
    localparam int FB = FW * WW;

    logic          clock, reset, sck, ss_n, mosi, miso;
    logic [FB-1:0] tx_frame, rx_frame;
    logic          rx_valid, frame_error, busy;

    int n_checks = 0;
    int n_pass   = 0;
    int n_rxv    = 0;
    int n_ferr   = 0;

    logic [WW-1:0] mosi_words [8];
    logic [WW-1:0] tx_snap [FW];
    logic [FB-1:0] exp_rx;

    myo_spi_slave #(.WORD_WIDTH(WW), .FRAME_WORDS(FW)) dut (
        .clock(clock), .reset(reset), .sck(sck), .ss_n(ss_n), .mosi(mosi), .miso(miso),
        .tx_frame(tx_frame), .rx_frame(rx_frame), .rx_valid(rx_valid),
        .frame_error(frame_error), .busy(busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Count result pulses away from the active edge.
    always @(negedge clock) begin
        if (rx_valid === 1'b1) n_rxv++;
        if (frame_error === 1'b1) n_ferr++;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Word k the master should see on miso, from the frame snapshot taken at frame start.
    function automatic logic [WW-1:0] exp_tx_word(input int k);
        logic [WW-1:0] acc;
        acc = '0;
        if (k >= FW) return '0;
`ifdef MYO_SPI_SLAVE_CHECKSUM_EN
        if (k == FW - 1) begin
            for (int j = 0; j < FW - 1; j++) acc = acc ^ tx_snap[j];
            return acc;
        end
`endif
        return tx_snap[k];
    endfunction

    function automatic bit frame_good(input int nbits);
        logic [WW-1:0] acc;
        acc = '0;
        if (nbits != FB) return 1'b0;
`ifdef MYO_SPI_SLAVE_CHECKSUM_EN
        for (int j = 0; j < FW - 1; j++) acc = acc ^ mosi_words[j];
        if (acc != mosi_words[FW-1]) return 1'b0;
`endif
        return 1'b1;
    endfunction

    task automatic send_bit(input logic b, output logic m);
        mosi = b;
        repeat (4) @(negedge clock);
        m   = miso;
        sck = 1'b1;
        repeat (4) @(negedge clock);
        sck = 1'b0;
    endtask

    task automatic run_frame(input string tag, input int nbits, input bit scramble);
        logic [WW-1:0] got_w [8];
        logic          m;
        int            nb0, ne0;
        bit            good;
        for (int k = 0; k < FW; k++) tx_snap[k] = tx_frame[(FW-1-k)*WW +: WW];
        for (int k = 0; k < 8; k++) got_w[k] = '0;
        nb0 = n_rxv;
        ne0 = n_ferr;
        @(negedge clock);
        ss_n = 1'b0;
        repeat (6) @(negedge clock);
        check_val({tag, "_busy_on"}, 64'(busy), 64'd1);
        if (scramble) tx_frame = {$urandom(), $urandom()};
        for (int i = 0; i < nbits; i++) begin
            send_bit(mosi_words[i/WW][WW-1-(i%WW)], m);
            got_w[i/WW][WW-1-(i%WW)] = m;
        end
        for (int k = 0; k < nbits / WW; k++)
            check_val($sformatf("%s_miso_w%0d", tag, k), 64'(got_w[k]), 64'(exp_tx_word(k)));
        repeat (2) @(negedge clock);
        ss_n = 1'b1;
        repeat (10) @(negedge clock);
        good = frame_good(nbits);
        if (good) for (int k = 0; k < FW; k++) exp_rx[(FW-1-k)*WW +: WW] = mosi_words[k];
        check_val({tag, "_rx_valid"}, 64'(n_rxv - nb0), good ? 64'd1 : 64'd0);
        check_val({tag, "_frame_error"}, 64'(n_ferr - ne0), good ? 64'd0 : 64'd1);
        check_val({tag, "_rx_frame"}, rx_frame, exp_rx);
        check_val({tag, "_busy_off"}, 64'(busy), 64'd0);
        check_val({tag, "_miso_idle"}, 64'(miso), 64'd0);
    endtask

    task automatic random_words();
        for (int k = 0; k < 8; k++) mosi_words[k] = WW'($urandom());
`ifdef MYO_SPI_SLAVE_CHECKSUM_EN
        if ($urandom_range(0, 3) != 0) mosi_words[FW-1] = mosi_words[0] ^ mosi_words[1] ^ mosi_words[2];
`endif
    endtask

    initial begin
        logic m;
        int   nb0, ne0;
        reset = 1'b1; ss_n = 1'b1; sck = 1'b0; mosi = 1'b0; tx_frame = '0;
        exp_rx = '0;
        for (int k = 0; k < 8; k++) mosi_words[k] = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_val("rst_miso", 64'(miso), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_rx_valid", 64'(rx_valid), 64'd0);
        check_val("rst_frame_error", 64'(frame_error), 64'd0);
        check_val("rst_rx_frame", rx_frame, 64'd0);
        repeat (4) @(negedge clock);

`ifdef MYO_SPI_SLAVE_CHECKSUM_EN
        tx_frame = 64'h0001_0002_0004_BEEF;
        mosi_words[0] = 16'h0001; mosi_words[1] = 16'h0002;
        mosi_words[2] = 16'h0004; mosi_words[3] = 16'h0007;
        run_frame("csum_good", FB, 1'b0);
        mosi_words[3] = 16'h0006;
        run_frame("csum_bad", FB, 1'b0);
`else
        tx_frame = 64'h1111_2222_3333_4444;
        mosi_words[0] = 16'hAAAA; mosi_words[1] = 16'h5555;
        mosi_words[2] = 16'h0F0F; mosi_words[3] = 16'hF0F0;
        run_frame("good", FB, 1'b0);
`endif
        random_words();
        tx_frame = {$urandom(), $urandom()};
        run_frame("short", 3 * WW, 1'b0);
        random_words();
        run_frame("partial", FB + 5, 1'b0);
        random_words();
        run_frame("overrun", FB + WW, 1'b0);

        for (int r = 0; r < 4; r++) begin
            random_words();
            tx_frame = {$urandom(), $urandom()};
            run_frame($sformatf("rand%0d", r), FB, 1'b1);
        end
        random_words();
        run_frame("rand_len", $urandom_range(1, FB + WW), 1'b0);

        // Reset after 20 bits with ss_n held low: frame dropped, no pulse, re-arm only after ss_n high.
        random_words();
        nb0 = n_rxv;
        ne0 = n_ferr;
        @(negedge clock);
        ss_n = 1'b0;
        repeat (6) @(negedge clock);
        for (int i = 0; i < 20; i++) send_bit(mosi_words[i/WW][WW-1-(i%WW)], m);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_val("midrst_busy", 64'(busy), 64'd0);
        check_val("midrst_miso", 64'(miso), 64'd0);
        for (int i = 0; i < 12; i++) send_bit(1'b1, m);
        check_val("midrst_busy_hold", 64'(busy), 64'd0);
        ss_n = 1'b1;
        repeat (10) @(negedge clock);
        exp_rx = '0;
        check_val("midrst_rx_valid", 64'(n_rxv - nb0), 64'd0);
        check_val("midrst_frame_error", 64'(n_ferr - ne0), 64'd0);
        check_val("midrst_rx_frame", rx_frame, exp_rx);
        random_words();
        mosi_words[FW-1] = mosi_words[0] ^ mosi_words[1] ^ mosi_words[2];
        tx_frame = {$urandom(), $urandom()};
        run_frame("after_rst", FB, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
